// File: rtl/fx_writeback_sequencer_pkg.sv
// Shared types and constants for the FX writeback sequencer: unit codes,
// register-file address map, the buffered packet layout and the issue states.
package fx_writeback_sequencer_pkg;

  localparam logic [1:0] FX_UNIT_CODE = 2'd0;
  localparam logic [1:0] LS_UNIT_CODE = 2'd1;
  localparam logic [1:0] BR_UNIT_CODE = 2'd2;
  localparam logic [1:0] CR_UNIT_CODE = 2'd3;

  localparam int ADDR_W          = 6;
  localparam int DATA_W          = 64;
  localparam int NIBBLE_W        = 4;
  localparam int GPR_BASE        = 0;
  localparam int GPR_COUNT       = 32;
  localparam int CR_BASE_DEFAULT = 32;
  localparam int CR_FIELD_COUNT  = 8;

  // Data fields use big-endian bit numbering: bit 0 is the MSB.
  typedef struct packed {
    logic              en1;
    logic              en2;
    logic [ADDR_W-1:0] addr1;
    logic [ADDR_W-1:0] addr2;
    logic [0:DATA_W-1] val1;
    logic [0:NIBBLE_W-1] nibble;
  } wb_packet_t;

  localparam int PACKET_W = $bits(wb_packet_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_W1   = 2'd1,
    ST_W2   = 2'd2
  } issue_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int lo, input int count);
    return (int'(addr) >= lo) && (int'(addr) < lo + count);
  endfunction

endpackage

// File: rtl/fx_writeback_sequencer_sync_fifo.sv
// Small packet FIFO with a combinational view of the head and the entry behind
// it, so the issue logic can move to the next packet without a bubble.
module fx_writeback_sequencer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [WIDTH-1:0]       next_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_next_ptr;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;
  assign rd_next_ptr = rd_ptr_q + PTR_W'(1);
  assign head_o      = mem_q[rd_ptr_q];
  assign next_o      = mem_q[rd_next_ptr];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_next_ptr;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fx_writeback_sequencer.sv
// Buffers FX result packets and serialises them onto the single register-file
// write port, reg1 (GPR) slot first, then reg2 (CR field) slot.
module fx_writeback_sequencer
  import fx_writeback_sequencer_pkg::*;
#(
  parameter int         DEPTH      = 4,
  parameter logic [1:0] FXUnitCode = FX_UNIT_CODE,
  parameter int         CRBase     = CR_BASE_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  functionalUnitCode_i,
  input  logic        reg1WritebackEnable_i,
  input  logic        reg2WritebackEnable_i,
  input  logic [5:0]  reg1WritebackAddress_i,
  input  logic [5:0]  reg2WritebackAddress_i,
  input  logic [0:63] reg1WritebackVal_i,
  input  logic [0:63] reg2WritebackVal_i,
  output logic        regWriteEnable_o,
  output logic [5:0]  regWriteAddress_o,
  output logic [0:63] regWriteVal_o,
  output logic        busy_o,
  output logic [7:0]  droppedCount_o
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  wb_packet_t       pkt_in;
  wb_packet_t       fifo_head;
  wb_packet_t       fifo_next;
  wb_packet_t       cur_pkt;
  logic             accept;
  logic             fifo_push, fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             has_next, start_new, slot_ok;
  logic             unused_val2_bits;

  issue_state_e state_q, state_d;
  logic         wen_q, wen_d;
  logic [5:0]   waddr_q, waddr_d;
  logic [0:63]  wval_q, wval_d;
  logic [7:0]   dropped_q, dropped_d;

  assign unused_val2_bits = ^reg2WritebackVal_i[4:63];

  always_comb begin
    pkt_in.en1    = reg1WritebackEnable_i;
    pkt_in.en2    = reg2WritebackEnable_i;
    pkt_in.addr1  = reg1WritebackAddress_i;
    pkt_in.addr2  = reg2WritebackAddress_i;
    pkt_in.val1   = reg1WritebackVal_i;
    pkt_in.nibble = reg2WritebackVal_i[0:3];
  end

  // Packets with no enables are accepted but never occupy a FIFO entry.
  assign ready_o   = !fifo_full;
  assign accept    = valid_i && ready_o && (functionalUnitCode_i == FXUnitCode);
  assign fifo_push = accept && (reg1WritebackEnable_i || reg2WritebackEnable_i);
  assign has_next  = (fifo_count > CNT_W'(1));

  fx_writeback_sequencer_sync_fifo #(
    .WIDTH (PACKET_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .data_i  (pkt_in),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .next_o  (fifo_next),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The head stays in the FIFO while its last slot is on the port; it is
  // popped on the edge that leaves that slot, issuing the next entry at once.
  always_comb begin
    state_d   = ST_IDLE;
    fifo_pop  = 1'b0;
    start_new = 1'b0;
    cur_pkt   = fifo_head;
    slot_ok   = 1'b0;
    wen_d     = 1'b0;
    waddr_d   = '0;
    wval_d    = '0;
    dropped_d = dropped_q;

    case (state_q)
      ST_IDLE: start_new = !fifo_empty;
      ST_W1: begin
        if (fifo_head.en2) begin
          state_d = ST_W2;
        end else begin
          fifo_pop  = 1'b1;
          start_new = has_next;
        end
      end
      ST_W2: begin
        fifo_pop  = 1'b1;
        start_new = has_next;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_new) begin
      cur_pkt = (state_q == ST_IDLE) ? fifo_head : fifo_next;
      state_d = cur_pkt.en1 ? ST_W1 : ST_W2;
    end

    // A reserved address still consumes its slot so ordering is unchanged.
    case (state_d)
      ST_W1: begin
        slot_ok = addr_in_range(cur_pkt.addr1, GPR_BASE, GPR_COUNT);
        if (slot_ok) begin
          wen_d   = 1'b1;
          waddr_d = cur_pkt.addr1;
          wval_d  = cur_pkt.val1;
        end
      end
      ST_W2: begin
        slot_ok = addr_in_range(cur_pkt.addr2, CRBase, CR_FIELD_COUNT);
        if (slot_ok) begin
          wen_d   = 1'b1;
          waddr_d = cur_pkt.addr2;
          wval_d  = {cur_pkt.nibble, 60'b0};
        end
      end
      default: slot_ok = 1'b1;
    endcase

    if (!slot_ok && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= ST_IDLE;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wval_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wval_q    <= wval_d;
      dropped_q <= dropped_d;
    end
  end

  assign regWriteEnable_o  = wen_q;
  assign regWriteAddress_o = waddr_q;
  assign regWriteVal_o     = wval_q;
  assign droppedCount_o    = dropped_q;
  assign busy_o            = !fifo_empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_fx_writeback_sequencer.sv
// Scoreboard bench: each accepted packet queues its expected writes with the
// cycle they must appear in; a forked monitor checks every write strobe.
module tb_fx_writeback_sequencer;

  logic        clock_i;
  logic        reset_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  functionalUnitCode_i;
  logic        reg1WritebackEnable_i;
  logic        reg2WritebackEnable_i;
  logic [5:0]  reg1WritebackAddress_i;
  logic [5:0]  reg2WritebackAddress_i;
  logic [0:63] reg1WritebackVal_i;
  logic [0:63] reg2WritebackVal_i;
  logic        regWriteEnable_o;
  logic [5:0]  regWriteAddress_o;
  logic [0:63] regWriteVal_o;
  logic        busy_o;
  logic [7:0]  droppedCount_o;

  typedef struct {
    logic [5:0]  addr;
    logic [63:0] val;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   slot_free = 0;

  fx_writeback_sequencer dut (
    .clock_i                (clock_i),
    .reset_i                (reset_i),
    .valid_i                (valid_i),
    .ready_o                (ready_o),
    .functionalUnitCode_i   (functionalUnitCode_i),
    .reg1WritebackEnable_i  (reg1WritebackEnable_i),
    .reg2WritebackEnable_i  (reg2WritebackEnable_i),
    .reg1WritebackAddress_i (reg1WritebackAddress_i),
    .reg2WritebackAddress_i (reg2WritebackAddress_i),
    .reg1WritebackVal_i     (reg1WritebackVal_i),
    .reg2WritebackVal_i     (reg2WritebackVal_i),
    .regWriteEnable_o       (regWriteEnable_o),
    .regWriteAddress_o      (regWriteAddress_o),
    .regWriteVal_o          (regWriteVal_o),
    .busy_o                 (busy_o),
    .droppedCount_o         (droppedCount_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  always @(posedge clock_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clock_i);
      if (reset_i && regWriteEnable_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual addr=%0d val=%h cyc=%0d required none",
                   regWriteAddress_o, regWriteVal_o, cyc);
        end else begin
          e = exp_q.pop_front();
          if (regWriteAddress_o !== e.addr || regWriteVal_o !== e.val || cyc != e.cyc) begin
            errors++;
            $display("FAIL write actual addr=%0d val=%h cyc=%0d required addr=%0d val=%h cyc=%0d",
                     regWriteAddress_o, regWriteVal_o, cyc, e.addr, e.val, e.cyc);
          end else begin
            $display("write addr=%0d val=%h cyc=%0d ok", e.addr, e.val, cyc);
          end
        end
      end
    end
  endtask

  // Present one packet; stalls while ready_o is low. Expected writes occupy
  // consecutive port slots starting no earlier than the cycle after acceptance.
  task automatic send(input logic [1:0] code, input logic e1, input logic e2,
                      input logic [5:0] a1, input logic [5:0] a2,
                      input logic [63:0] v1, input logic [3:0] nib);
    int   n = 0;
    int   s;
    exp_t e;
    @(negedge clock_i);
    valid_i                = 1'b1;
    functionalUnitCode_i   = code;
    reg1WritebackEnable_i  = e1;
    reg2WritebackEnable_i  = e2;
    reg1WritebackAddress_i = a1;
    reg2WritebackAddress_i = a2;
    reg1WritebackVal_i     = v1;
    reg2WritebackVal_i     = {nib, {60{1'b1}}};
    if (code == 2'd0) begin
      while (!ready_o && n < 200) begin
        @(negedge clock_i);
        n++;
      end
      if (!ready_o) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout actual ready=0 required ready=1");
      end else if (e1 || e2) begin
        s = (cyc + 2 > slot_free) ? cyc + 2 : slot_free;
        if (e1) begin
          if (a1 < 6'd32) begin
            e.addr = a1; e.val = v1; e.cyc = s;
            exp_q.push_back(e);
          end
          s++;
        end
        if (e2) begin
          if (a2 >= 6'd32 && a2 <= 6'd39) begin
            e.addr = a2; e.val = {nib, 60'b0}; e.cyc = s;
            exp_q.push_back(e);
          end
          s++;
        end
        slot_free = s;
      end
    end
    @(posedge clock_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock_i);
    while ((busy_o || exp_q.size() != 0) && n < 400) begin
      @(negedge clock_i);
      n++;
    end
    @(negedge clock_i);
    checks++;
    if (busy_o || exp_q.size() != 0) begin
      errors++;
      $display("FAIL idle_wait actual busy=%0d pending=%0d required busy=0 pending=0",
               busy_o, exp_q.size());
    end
  endtask

  initial begin
    reset_i                = 1'b0;
    valid_i                = 1'b0;
    functionalUnitCode_i   = 2'd0;
    reg1WritebackEnable_i  = 1'b0;
    reg2WritebackEnable_i  = 1'b0;
    reg1WritebackAddress_i = '0;
    reg2WritebackAddress_i = '0;
    reg1WritebackVal_i     = '0;
    reg2WritebackVal_i     = '0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clock_i);
    chk("rst_ready", ready_o, 1);
    chk("rst_wen", regWriteEnable_o, 0);
    chk("rst_addr", regWriteAddress_o, 0);
    chk("rst_val", regWriteVal_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_dropped", droppedCount_o, 0);
    reset_i = 1'b1;

    // Single packet, then an en2-only packet at the top CR field and a GPR31-only packet.
    send(2'd0, 1, 1, 6'd5, 6'd32, 64'h1234, 4'b0100);
    wait_idle();
    send(2'd0, 0, 1, 6'd0, 6'd39, 64'h0, 4'b1111);
    send(2'd0, 1, 0, 6'd31, 6'd0, 64'hDEAD_BEEF_0000_0031, 4'b0000);
    wait_idle();

    // Five back-to-back two-write packets fill the FIFO; one pop frees a slot.
    for (int i = 0; i < 5; i++)
      send(2'd0, 1, 1, 6'(i + 1), 6'(32 + i), 64'hA000_0000_0000_0000 + 64'(i), 4'(i + 1));
    chk("fill_ready_low", ready_o, 0);
    chk("fill_busy", busy_o, 1);
    @(posedge clock_i);
    #1;
    chk("ready_after_pop", ready_o, 1);
    wait_idle();

    // Reserved addresses: the suppressed slot still holds its cycle.
    send(2'd0, 1, 1, 6'd40, 6'd33, 64'h5555, 4'b1010);
    wait_idle();
    chk("dropped_one", droppedCount_o, 1);
    send(2'd0, 1, 1, 6'd31, 6'd31, 64'h7777, 4'b0001);
    wait_idle();
    chk("dropped_cr_low", droppedCount_o, 2);
    send(2'd0, 1, 1, 6'd32, 6'd40, 64'h8888, 4'b0010);
    wait_idle();
    chk("dropped_both", droppedCount_o, 4);

    // Foreign unit codes are not accepted; empty packets leave nothing behind.
    send(2'd1, 1, 1, 6'd3, 6'd34, 64'h9999, 4'b0011);
    chk("filter_busy", busy_o, 0);
    send(2'd3, 1, 0, 6'd4, 6'd0, 64'hAAAA, 4'b0000);
    repeat (4) @(negedge clock_i);
    chk("filter_busy_later", busy_o, 0);
    send(2'd0, 0, 0, 6'd6, 6'd35, 64'hBBBB, 4'b0101);
    chk("empty_pkt_busy", busy_o, 0);
    chk("empty_pkt_ready", ready_o, 1);
    repeat (3) @(negedge clock_i);
    chk("dropped_unchanged", droppedCount_o, 4);

    // Reset while packet B sits between its reg1 and reg2 slots, C and D queued.
    send(2'd0, 1, 1, 6'd10, 6'd36, 64'h0A, 4'b1000);
    send(2'd0, 1, 1, 6'd11, 6'd37, 64'h0B, 4'b1001);
    send(2'd0, 1, 1, 6'd12, 6'd38, 64'h0C, 4'b1100);
    send(2'd0, 1, 1, 6'd13, 6'd39, 64'h0D, 4'b1110);
    @(negedge clock_i);
    #2;
    reset_i = 1'b0;
    #1;
    chk("midrst_wen", regWriteEnable_o, 0);
    chk("midrst_addr", regWriteAddress_o, 0);
    chk("midrst_val", regWriteVal_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_ready", ready_o, 1);
    chk("midrst_dropped", droppedCount_o, 0);
    exp_q.delete();
    slot_free = 0;
    @(negedge clock_i);
    reset_i = 1'b1;
    repeat (10) @(negedge clock_i);
    chk("postrst_ready", ready_o, 1);
    chk("postrst_busy", busy_o, 0);

    // Saturation: 260 reserved-address slots in total.
    for (int i = 0; i < 127; i++)
      send(2'd0, 1, 1, 6'd63, 6'(i % 32), 64'(i), 4'(i));
    wait_idle();
    chk("dropped_254", droppedCount_o, 254);
    send(2'd0, 1, 1, 6'd50, 6'd20, 64'h1, 4'h1);
    wait_idle();
    chk("dropped_sat", droppedCount_o, 255);
    send(2'd0, 1, 1, 6'd45, 6'd0, 64'h2, 4'h2);
    send(2'd0, 1, 1, 6'd44, 6'd1, 64'h3, 4'h3);
    wait_idle();
    chk("dropped_hold", droppedCount_o, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
